// File: rtl/alarm_ring_sequencer_pkg.sv
// Shared definitions for the multi-channel alarm ring sequencer:
// per-channel state encodings and the time-field widths.
package alarm_ring_sequencer_pkg;

    // Per-channel alarm state; encodings are fixed so debug tools can decode them.
    typedef enum logic [1:0] {
        ALARM_IDLE    = 2'b00,
        ALARM_RINGING = 2'b01,
        ALARM_SNOOZE  = 2'b10
    } alarm_state_e;

    // Widths of the hh:mm:ss fields.
    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;

    // Seconds in one minute, used to scale the snooze length.
    localparam int unsigned SECS_PER_MIN = 60;

    // True when the running hour:minute equals an alarm setting at second zero.
    function automatic logic time_match(
        input logic [HOUR_W-1:0] cur_hour,
        input logic [MIN_W-1:0]  cur_min,
        input logic [SEC_W-1:0]  cur_sec,
        input logic [HOUR_W-1:0] alm_hour,
        input logic [MIN_W-1:0]  alm_min
    );
        return (cur_hour == alm_hour) && (cur_min == alm_min) && (cur_sec == 6'd0);
    endfunction

endpackage

// File: rtl/alarm_ring_sequencer_if.sv
// Bundle of the alarm sequencer's time, configuration, button and status signals.
// The master modport drives time/config/buttons; the slave (the sequencer) drives status.
interface alarm_ring_sequencer_if #(
    parameter int NUM_ALARMS = 2
);
    logic                      i_sec_tick;
    logic [4:0]                i_cur_hour;
    logic [5:0]                i_cur_min;
    logic [5:0]                i_cur_sec;
    logic [5*NUM_ALARMS-1:0]   i_alarm_hour;
    logic [6*NUM_ALARMS-1:0]   i_alarm_min;
    logic [NUM_ALARMS-1:0]     i_alarm_en;
    logic                      i_btn_stop;
    logic                      i_btn_snooze;
    logic [NUM_ALARMS-1:0]     o_ring;
    logic [NUM_ALARMS-1:0]     o_snoozing;
    logic [NUM_ALARMS-1:0]     o_missed;
    logic                      o_buzzer;

    modport master (
        output i_sec_tick, i_cur_hour, i_cur_min, i_cur_sec,
        output i_alarm_hour, i_alarm_min, i_alarm_en,
        output i_btn_stop, i_btn_snooze,
        input  o_ring, o_snoozing, o_missed, o_buzzer
    );

    modport slave (
        input  i_sec_tick, i_cur_hour, i_cur_min, i_cur_sec,
        input  i_alarm_hour, i_alarm_min, i_alarm_en,
        input  i_btn_stop, i_btn_snooze,
        output o_ring, o_snoozing, o_missed, o_buzzer
    );
endinterface

// File: rtl/alarm_ring_sequencer_channel.sv
// One alarm channel: IDLE/RINGING/SNOOZE state machine, ring and snooze
// second counters, sticky MISSED flag and match edge detector.
// Optional feature macro: ALARM_SNOOZE_LIMIT_EN adds a per-event snooze
// counter that refuses BTN_SNOOZE once MAX_SNOOZE snoozes have been used.
module alarm_ring_sequencer_channel
    import alarm_ring_sequencer_pkg::*;
#(
    parameter int unsigned RING_SECONDS   = 60,
    parameter int unsigned SNOOZE_MINUTES = 5
`ifdef ALARM_SNOOZE_LIMIT_EN
    ,
    parameter int unsigned MAX_SNOOZE     = 3
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_match,
    input  logic i_sec_tick,
    input  logic i_stop,
    input  logic i_snooze,
    output logic o_ring,
    output logic o_snoozing,
    output logic o_missed
);

    localparam int unsigned SNOOZE_TICKS = SNOOZE_MINUTES * SECS_PER_MIN;
    localparam int unsigned RING_W       = $clog2(RING_SECONDS + 1);
    localparam int unsigned SNZ_W        = $clog2(SNOOZE_TICKS + 1);

    localparam logic [RING_W-1:0] RING_ZERO = RING_W'(0);
    localparam logic [RING_W-1:0] RING_ONE  = RING_W'(1);
    // Last count value before the tick that ends the ring period.
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECONDS - 1);
    localparam logic [SNZ_W-1:0]  SNZ_ZERO  = SNZ_W'(0);
    localparam logic [SNZ_W-1:0]  SNZ_ONE   = SNZ_W'(1);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_TICKS);

    alarm_state_e        r_state;
    alarm_state_e        w_state_nxt;
    logic [RING_W-1:0]   r_ring_cnt;
    logic [RING_W-1:0]   w_ring_cnt_nxt;
    logic [SNZ_W-1:0]    r_snooze_cnt;
    logic [SNZ_W-1:0]    w_snooze_cnt_nxt;
    logic                r_missed;
    logic                w_missed_nxt;
    logic                r_prev_match;
    logic                r_ring;
    logic                r_snoozing;
    logic                w_trigger;
    logic                w_snooze_ok;

`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam int unsigned EVT_W = $clog2(MAX_SNOOZE + 1);
    localparam logic [EVT_W-1:0] EVT_ZERO = EVT_W'(0);
    localparam logic [EVT_W-1:0] EVT_ONE  = EVT_W'(1);
    localparam logic [EVT_W-1:0] EVT_MAX  = EVT_W'(MAX_SNOOZE);

    logic [EVT_W-1:0]    r_snz_events;
    logic [EVT_W-1:0]    w_snz_events_nxt;

    assign w_snooze_ok = (r_snz_events < EVT_MAX);
`else
    assign w_snooze_ok = 1'b1;
`endif

    // A new alarm event only on the rising edge of the match condition.
    assign w_trigger = i_match & ~r_prev_match;

    // Next-state, counter and MISSED logic; disable beats STOP beats SNOOZE beats counting.
    always_comb begin
        w_state_nxt      = r_state;
        w_ring_cnt_nxt   = r_ring_cnt;
        w_snooze_cnt_nxt = r_snooze_cnt;
`ifdef ALARM_SNOOZE_LIMIT_EN
        w_snz_events_nxt = r_snz_events;
`endif
        // STOP clears MISSED regardless of state.
        if (i_stop) begin
            w_missed_nxt = 1'b0;
        end else begin
            w_missed_nxt = r_missed;
        end

        if (!i_en) begin
            w_state_nxt      = ALARM_IDLE;
            w_ring_cnt_nxt   = RING_ZERO;
            w_snooze_cnt_nxt = SNZ_ZERO;
            w_missed_nxt     = 1'b0;
`ifdef ALARM_SNOOZE_LIMIT_EN
            w_snz_events_nxt = EVT_ZERO;
`endif
        end else begin
            case (r_state)
                ALARM_IDLE: begin
                    if (!i_stop && w_trigger) begin
                        w_state_nxt    = ALARM_RINGING;
                        w_ring_cnt_nxt = RING_ZERO;
`ifdef ALARM_SNOOZE_LIMIT_EN
                        w_snz_events_nxt = EVT_ZERO;
`endif
                    end else begin
                        w_state_nxt = ALARM_IDLE;
                    end
                end
                ALARM_RINGING: begin
                    // A trigger while already ringing is deliberately ignored.
                    if (i_stop) begin
                        w_state_nxt    = ALARM_IDLE;
                        w_ring_cnt_nxt = RING_ZERO;
                    end else if (i_snooze && w_snooze_ok) begin
                        w_state_nxt      = ALARM_SNOOZE;
                        w_snooze_cnt_nxt = SNZ_LOAD;
`ifdef ALARM_SNOOZE_LIMIT_EN
                        w_snz_events_nxt = r_snz_events + EVT_ONE;
`endif
                    end else if (i_sec_tick) begin
                        if (r_ring_cnt == RING_LAST) begin
                            w_state_nxt    = ALARM_IDLE;
                            w_ring_cnt_nxt = RING_ZERO;
                            w_missed_nxt   = 1'b1;
                        end else begin
                            w_ring_cnt_nxt = r_ring_cnt + RING_ONE;
                        end
                    end else begin
                        w_state_nxt = ALARM_RINGING;
                    end
                end
                ALARM_SNOOZE: begin
                    if (i_stop) begin
                        w_state_nxt      = ALARM_IDLE;
                        w_snooze_cnt_nxt = SNZ_ZERO;
                    end else if (w_trigger) begin
                        // Fresh alarm event: ring again with a clean snooze budget.
                        w_state_nxt      = ALARM_RINGING;
                        w_ring_cnt_nxt   = RING_ZERO;
                        w_snooze_cnt_nxt = SNZ_ZERO;
`ifdef ALARM_SNOOZE_LIMIT_EN
                        w_snz_events_nxt = EVT_ZERO;
`endif
                    end else if (i_sec_tick) begin
                        if (r_snooze_cnt == SNZ_ONE) begin
                            w_state_nxt      = ALARM_RINGING;
                            w_ring_cnt_nxt   = RING_ZERO;
                            w_snooze_cnt_nxt = SNZ_ZERO;
                        end else begin
                            w_snooze_cnt_nxt = r_snooze_cnt - SNZ_ONE;
                        end
                    end else begin
                        w_state_nxt = ALARM_SNOOZE;
                    end
                end
                default: begin
                    w_state_nxt      = ALARM_IDLE;
                    w_ring_cnt_nxt   = RING_ZERO;
                    w_snooze_cnt_nxt = SNZ_ZERO;
                end
            endcase
        end
    end

    // State, counters, edge detector and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ALARM_IDLE;
            r_ring_cnt   <= RING_ZERO;
            r_snooze_cnt <= SNZ_ZERO;
            r_missed     <= 1'b0;
            // Held high so an alarm matching the time at reset release does not fire.
            r_prev_match <= 1'b1;
            r_ring       <= 1'b0;
            r_snoozing   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ring_cnt   <= w_ring_cnt_nxt;
            r_snooze_cnt <= w_snooze_cnt_nxt;
            r_missed     <= w_missed_nxt;
            r_prev_match <= i_match;
            r_ring       <= (w_state_nxt == ALARM_RINGING);
            r_snoozing   <= (w_state_nxt == ALARM_SNOOZE);
        end
    end

`ifdef ALARM_SNOOZE_LIMIT_EN
    // Snoozes used within the current alarm event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snz_events <= EVT_ZERO;
        end else begin
            r_snz_events <= w_snz_events_nxt;
        end
    end
`endif

    assign o_ring     = r_ring;
    assign o_snoozing = r_snoozing;
    assign o_missed   = r_missed;

endmodule

// File: rtl/alarm_ring_sequencer.sv
// Multi-channel alarm ring sequencer: slices per-channel alarm settings,
// detects hh:mm:00 matches, runs one alarm channel per alarm and registers BUZZER.
// Optional feature macro: ALARM_SNOOZE_LIMIT_EN (limits snoozes per event to MAX_SNOOZE).
module alarm_ring_sequencer
    import alarm_ring_sequencer_pkg::*;
#(
    parameter int unsigned NUM_ALARMS     = 2,
    parameter int unsigned RING_SECONDS   = 60,
    parameter int unsigned SNOOZE_MINUTES = 5,
    parameter int unsigned MAX_SNOOZE     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    alarm_ring_sequencer_if.slave bus
);

    logic [NUM_ALARMS-1:0] w_match;
    logic [NUM_ALARMS-1:0] w_ring;
    logic [NUM_ALARMS-1:0] w_snoozing;
    logic [NUM_ALARMS-1:0] w_missed;
    logic                  r_buzzer;

    for (genvar g = 0; g < int'(NUM_ALARMS); g++) begin : g_ch
        assign w_match[g] = bus.i_alarm_en[g] &
                            time_match(bus.i_cur_hour, bus.i_cur_min, bus.i_cur_sec,
                                       bus.i_alarm_hour[HOUR_W*g +: HOUR_W],
                                       bus.i_alarm_min[MIN_W*g +: MIN_W]);

        alarm_ring_sequencer_channel #(
            .RING_SECONDS   (RING_SECONDS),
            .SNOOZE_MINUTES (SNOOZE_MINUTES)
`ifdef ALARM_SNOOZE_LIMIT_EN
            ,
            .MAX_SNOOZE     (MAX_SNOOZE)
`endif
        ) u_channel (
            .clk        (clk),
            .rst        (rst),
            .i_en       (bus.i_alarm_en[g]),
            .i_match    (w_match[g]),
            .i_sec_tick (bus.i_sec_tick),
            .i_stop     (bus.i_btn_stop),
            .i_snooze   (bus.i_btn_snooze),
            .o_ring     (w_ring[g]),
            .o_snoozing (w_snoozing[g]),
            .o_missed   (w_missed[g])
        );
    end

    // Buzzer follows any ringing channel one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buzzer <= 1'b0;
        end else begin
            r_buzzer <= |w_ring;
        end
    end

    assign bus.o_ring     = w_ring;
    assign bus.o_snoozing = w_snoozing;
    assign bus.o_missed   = w_missed;
    assign bus.o_buzzer   = r_buzzer;

endmodule

// File: tb/tb_alarm_ring_sequencer.sv
// Directed self-checking bench for alarm_ring_sequencer (2 channels, 60 s ring,
// 5 min snooze). Inputs change on falling edges; outputs are sampled on falling edges.
module tb_alarm_ring_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    alarm_ring_sequencer_if #(.NUM_ALARMS(2)) u_if ();

    alarm_ring_sequencer #(
        .NUM_ALARMS     (2),
        .RING_SECONDS   (60),
        .SNOOZE_MINUTES (5),
        .MAX_SNOOZE     (3)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        u_if.i_cur_hour = h;
        u_if.i_cur_min  = m;
        u_if.i_cur_sec  = s;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        u_if.i_sec_tick = 1'b1;
        @(negedge clk);
        u_if.i_sec_tick = 1'b0;
    endtask

    task automatic press(input logic stop, input logic snooze);
        @(negedge clk);
        u_if.i_btn_stop   = stop;
        u_if.i_btn_snooze = snooze;
        @(negedge clk);
        u_if.i_btn_stop   = 1'b0;
        u_if.i_btn_snooze = 1'b0;
    endtask

    // Present hh:mm:00 for one cycle then move to hh:mm:01.
    task automatic trigger_at(input logic [4:0] h, input logic [5:0] m);
        @(negedge clk);
        set_time(h, m, 6'd0);
        @(negedge clk);
        set_time(h, m, 6'd1);
    endtask

    task automatic test_reset();
        n_checks++; if (u_if.o_ring !== 2'b00) $display("FAIL reset_ring: got %b expected %b", u_if.o_ring, 2'b00); else n_pass++;
        n_checks++; if (u_if.o_snoozing !== 2'b00) $display("FAIL reset_snoozing: got %b expected %b", u_if.o_snoozing, 2'b00); else n_pass++;
        n_checks++; if (u_if.o_missed !== 2'b00) $display("FAIL reset_missed: got %b expected %b", u_if.o_missed, 2'b00); else n_pass++;
        n_checks++; if (u_if.o_buzzer !== 1'b0) $display("FAIL reset_buzzer: got %b expected %b", u_if.o_buzzer, 1'b0); else n_pass++;
        press(1'b0, 1'b1);
        n_checks++; if (u_if.o_snoozing !== 2'b00) $display("FAIL idle_snooze_ignored: got %b expected %b", u_if.o_snoozing, 2'b00); else n_pass++;
    endtask

    task automatic test_ring();
        trigger_at(5'd7, 6'd30);
        n_checks++; if (u_if.o_ring !== 2'b01) $display("FAIL ring_rise: got %b expected %b", u_if.o_ring, 2'b01); else n_pass++;
        n_checks++; if (u_if.o_buzzer !== 1'b0) $display("FAIL buzzer_lag: got %b expected %b", u_if.o_buzzer, 1'b0); else n_pass++;
        step();
        n_checks++; if (u_if.o_buzzer !== 1'b1) $display("FAIL buzzer_rise: got %b expected %b", u_if.o_buzzer, 1'b1); else n_pass++;
        press(1'b1, 1'b0);
        n_checks++; if (u_if.o_ring !== 2'b00) $display("FAIL stop_ring: got %b expected %b", u_if.o_ring, 2'b00); else n_pass++;
        step();
        n_checks++; if (u_if.o_buzzer !== 1'b0) $display("FAIL stop_buzzer: got %b expected %b", u_if.o_buzzer, 1'b0); else n_pass++;
    endtask

    task automatic test_snooze();
        trigger_at(5'd7, 6'd30);
        press(1'b0, 1'b1);
        n_checks++; if (u_if.o_snoozing !== 2'b01) $display("FAIL snooze_enter: got %b expected %b", u_if.o_snoozing, 2'b01); else n_pass++;
        n_checks++; if (u_if.o_ring !== 2'b00) $display("FAIL snooze_ring_off: got %b expected %b", u_if.o_ring, 2'b00); else n_pass++;
        repeat (299) tick();
        n_checks++; if (u_if.o_snoozing !== 2'b01) $display("FAIL snooze_299: got %b expected %b", u_if.o_snoozing, 2'b01); else n_pass++;
        tick();
        n_checks++; if (u_if.o_ring !== 2'b01) $display("FAIL snooze_expire_ring: got %b expected %b", u_if.o_ring, 2'b01); else n_pass++;
        n_checks++; if (u_if.o_snoozing !== 2'b00) $display("FAIL snooze_expire_snz: got %b expected %b", u_if.o_snoozing, 2'b00); else n_pass++;
        press(1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        trigger_at(5'd7, 6'd30);
        repeat (59) tick();
        n_checks++; if (u_if.o_ring !== 2'b01) $display("FAIL timeout_59_ring: got %b expected %b", u_if.o_ring, 2'b01); else n_pass++;
        n_checks++; if (u_if.o_missed !== 2'b00) $display("FAIL timeout_59_missed: got %b expected %b", u_if.o_missed, 2'b00); else n_pass++;
        tick();
        n_checks++; if (u_if.o_ring !== 2'b00) $display("FAIL timeout_60_ring: got %b expected %b", u_if.o_ring, 2'b00); else n_pass++;
        n_checks++; if (u_if.o_missed !== 2'b01) $display("FAIL timeout_60_missed: got %b expected %b", u_if.o_missed, 2'b01); else n_pass++;
        step();
        n_checks++; if (u_if.o_buzzer !== 1'b0) $display("FAIL timeout_buzzer: got %b expected %b", u_if.o_buzzer, 1'b0); else n_pass++;
        press(1'b1, 1'b0);
        n_checks++; if (u_if.o_missed !== 2'b00) $display("FAIL stop_clears_missed: got %b expected %b", u_if.o_missed, 2'b00); else n_pass++;
    endtask

    task automatic test_stop_snooze_same();
        @(negedge clk);
        u_if.i_alarm_hour = {5'd6, 5'd6};
        u_if.i_alarm_min  = {6'd0, 6'd0};
        u_if.i_alarm_en   = 2'b11;
        trigger_at(5'd6, 6'd0);
        n_checks++; if (u_if.o_ring !== 2'b11) $display("FAIL dual_ring: got %b expected %b", u_if.o_ring, 2'b11); else n_pass++;
        step();
        n_checks++; if (u_if.o_buzzer !== 1'b1) $display("FAIL dual_buzzer: got %b expected %b", u_if.o_buzzer, 1'b1); else n_pass++;
        press(1'b1, 1'b1);
        n_checks++; if (u_if.o_ring !== 2'b00) $display("FAIL stop_wins_ring: got %b expected %b", u_if.o_ring, 2'b00); else n_pass++;
        n_checks++; if (u_if.o_snoozing !== 2'b00) $display("FAIL stop_wins_snooze: got %b expected %b", u_if.o_snoozing, 2'b00); else n_pass++;
        step();
        n_checks++; if (u_if.o_buzzer !== 1'b0) $display("FAIL stop_wins_buzzer: got %b expected %b", u_if.o_buzzer, 1'b0); else n_pass++;
        u_if.i_alarm_hour = {5'd6, 5'd7};
        u_if.i_alarm_min  = {6'd0, 6'd30};
        u_if.i_alarm_en   = 2'b01;
        set_time(5'd7, 6'd30, 6'd1);
    endtask

    task automatic test_enable_and_reset();
        trigger_at(5'd7, 6'd30);
        @(negedge clk);
        u_if.i_alarm_en = 2'b00;
        @(negedge clk);
        n_checks++; if (u_if.o_ring !== 2'b00) $display("FAIL en_drop_ring: got %b expected %b", u_if.o_ring, 2'b00); else n_pass++;
        u_if.i_alarm_en = 2'b01;
        trigger_at(5'd7, 6'd30);
        repeat (60) tick();
        n_checks++; if (u_if.o_missed !== 2'b01) $display("FAIL en_missed_set: got %b expected %b", u_if.o_missed, 2'b01); else n_pass++;
        @(negedge clk);
        u_if.i_alarm_en = 2'b00;
        @(negedge clk);
        n_checks++; if (u_if.o_missed !== 2'b00) $display("FAIL en_drop_missed: got %b expected %b", u_if.o_missed, 2'b00); else n_pass++;
        u_if.i_alarm_en = 2'b01;
        // Reset while ringing, released with the alarm time still on the clock.
        trigger_at(5'd7, 6'd30);
        @(negedge clk);
        set_time(5'd7, 6'd30, 6'd0);
        rst = 1'b1;
        #1;
        n_checks++; if (u_if.o_ring !== 2'b00) $display("FAIL reset_mid_ring: got %b expected %b", u_if.o_ring, 2'b00); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();
        n_checks++; if (u_if.o_ring !== 2'b00) $display("FAIL reset_release_no_ring: got %b expected %b", u_if.o_ring, 2'b00); else n_pass++;
        set_time(5'd7, 6'd30, 6'd1);
        step();
        trigger_at(5'd7, 6'd30);
        n_checks++; if (u_if.o_ring !== 2'b01) $display("FAIL retrigger_after_reset: got %b expected %b", u_if.o_ring, 2'b01); else n_pass++;
        press(1'b1, 1'b0);
    endtask

    task automatic test_snooze_limit();
        trigger_at(5'd7, 6'd30);
        for (int k = 0; k < 3; k++) begin
            press(1'b0, 1'b1);
            n_checks++; if (u_if.o_snoozing !== 2'b01) $display("FAIL limit_snooze_%0d: got %b expected %b", k, u_if.o_snoozing, 2'b01); else n_pass++;
            repeat (300) tick();
            n_checks++; if (u_if.o_ring !== 2'b01) $display("FAIL limit_rering_%0d: got %b expected %b", k, u_if.o_ring, 2'b01); else n_pass++;
        end
        press(1'b0, 1'b1);
`ifdef ALARM_SNOOZE_LIMIT_EN
        n_checks++; if (u_if.o_ring !== 2'b01) $display("FAIL fourth_snooze_ignored: got %b expected %b", u_if.o_ring, 2'b01); else n_pass++;
        n_checks++; if (u_if.o_snoozing !== 2'b00) $display("FAIL fourth_snooze_no_snz: got %b expected %b", u_if.o_snoozing, 2'b00); else n_pass++;
`else
        n_checks++; if (u_if.o_snoozing !== 2'b01) $display("FAIL fourth_snooze_taken: got %b expected %b", u_if.o_snoozing, 2'b01); else n_pass++;
        n_checks++; if (u_if.o_ring !== 2'b00) $display("FAIL fourth_snooze_ring_off: got %b expected %b", u_if.o_ring, 2'b00); else n_pass++;
`endif
        press(1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t reached, required the bench to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        rst               = 1'b1;
        u_if.i_sec_tick   = 1'b0;
        u_if.i_btn_stop   = 1'b0;
        u_if.i_btn_snooze = 1'b0;
        u_if.i_alarm_hour = {5'd6, 5'd7};
        u_if.i_alarm_min  = {6'd0, 6'd30};
        u_if.i_alarm_en   = 2'b01;
        set_time(5'd0, 6'd0, 6'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step();
        test_reset();
        test_ring();
        test_snooze();
        test_timeout();
        test_stop_snooze_same();
        test_enable_and_reset();
        test_snooze_limit();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
